// File: rtl/branch_history_table.sv
// Branch history table: 2-bit saturating taken/not-taken counters indexed by PC,
// with resolved-branch and misprediction performance counters.
module branch_history_table #(
    parameter int INST_ADDR_WIDTH = 32,
    parameter int BHT_INDEX_WIDTH = 6,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lookup_valid_ID,
    input  logic [INST_ADDR_WIDTH-1:0] lookup_PC_ID,
    output logic                       predict_branch_taken_ID,
    input  logic                       update_valid_EX,
    input  logic [INST_ADDR_WIDTH-1:0] update_PC_EX,
    input  logic                       update_taken_EX,
    input  logic                       fix_predict_EX,
    output logic [CNT_WIDTH-1:0]       branch_cnt,
    output logic [CNT_WIDTH-1:0]       mispredict_cnt
);

    localparam int ENTRIES = 1 << BHT_INDEX_WIDTH;
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] ST  = 2'b11;

    logic [ENTRIES-1:0][1:0]    bht_q, bht_d;
    logic [CNT_WIDTH-1:0]       branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]       mispredict_cnt_q, mispredict_cnt_d;
    logic [BHT_INDEX_WIDTH-1:0] lookup_idx;
    logic [BHT_INDEX_WIDTH-1:0] update_idx;
    logic [1:0]                 cur_ctr;
    logic [1:0]                 nxt_ctr;

    assign lookup_idx = lookup_PC_ID[BHT_INDEX_WIDTH+1:2];
    assign update_idx = update_PC_EX[BHT_INDEX_WIDTH+1:2];
    assign cur_ctr    = bht_q[update_idx];

    // Reads the registered table, so a same-cycle update is not bypassed.
    assign predict_branch_taken_ID = lookup_valid_ID & bht_q[lookup_idx][1];

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

    always_comb begin
        nxt_ctr          = cur_ctr;
        bht_d            = bht_q;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (update_taken_EX) begin
            if (cur_ctr != ST) nxt_ctr = cur_ctr + 2'd1;
        end else begin
            if (cur_ctr != SNT) nxt_ctr = cur_ctr - 2'd1;
        end
        if (update_valid_EX) begin
            bht_d[update_idx] = nxt_ctr;
            if (!(&branch_cnt_q))
                branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
            if (fix_predict_EX && !(&mispredict_cnt_q))
                mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bht_q            <= {ENTRIES{WNT}};
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            bht_q            <= bht_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Scoreboard bench for branch_history_table: directed scenarios, counter
// saturation with a narrow count width, then randomized traffic.
module tb_branch_history_table;

    localparam int AW = 32;
    localparam int IW = 6;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          lookup_valid_ID;
    logic [AW-1:0] lookup_PC_ID;
    logic          predict_branch_taken_ID;
    logic          update_valid_EX;
    logic [AW-1:0] update_PC_EX;
    logic          update_taken_EX;
    logic          fix_predict_EX;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispredict_cnt;

    always #5 clk = ~clk;

    branch_history_table #(
        .INST_ADDR_WIDTH(AW),
        .BHT_INDEX_WIDTH(IW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lookup_valid_ID(lookup_valid_ID),
        .lookup_PC_ID(lookup_PC_ID),
        .predict_branch_taken_ID(predict_branch_taken_ID),
        .update_valid_EX(update_valid_EX),
        .update_PC_EX(update_PC_EX),
        .update_taken_EX(update_taken_EX),
        .fix_predict_EX(fix_predict_EX),
        .branch_cnt(branch_cnt),
        .mispredict_cnt(mispredict_cnt)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t pred_q[$];
    exp_t cnt_q[$];
    int   model[64];
    int   m_bc;
    int   m_mc;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    // One clock: drive at negedge, check prediction before the edge,
    // check counters after it.
    task automatic step(input string tag, input logic r, input logic lv,
                        input logic [31:0] lpc, input logic uv,
                        input logic [31:0] upc, input logic ut,
                        input logic fx);
        exp_t e;
        int   i;
        @(negedge clk);
        rst             = r;
        lookup_valid_ID = lv;
        lookup_PC_ID    = lpc;
        update_valid_EX = uv;
        update_PC_EX    = upc;
        update_taken_EX = ut;
        fix_predict_EX  = fx;
        e.tag = {tag, "_pred"};
        e.exp = (lv && model[idx(lpc)] >= 2) ? 32'd1 : 32'd0;
        pred_q.push_back(e);
        if (r) begin
            foreach (model[k]) model[k] = 1;
            m_bc = 0;
            m_mc = 0;
        end else if (uv) begin
            i = idx(upc);
            if (ut) begin
                if (model[i] < 3) model[i]++;
            end else begin
                if (model[i] > 0) model[i]--;
            end
            if (m_bc < CMAX) m_bc++;
            if (fx && m_mc < CMAX) m_mc++;
        end
        e.tag = {tag, "_bcnt"};
        e.exp = 32'(m_bc);
        cnt_q.push_back(e);
        e.tag = {tag, "_mcnt"};
        e.exp = 32'(m_mc);
        cnt_q.push_back(e);
        #1;
        e = pred_q.pop_front();
        check(e.tag, {31'b0, predict_branch_taken_ID}, e.exp);
        @(posedge clk);
        #1;
        e = cnt_q.pop_front();
        check(e.tag, 32'(branch_cnt), e.exp);
        e = cnt_q.pop_front();
        check(e.tag, 32'(mispredict_cnt), e.exp);
    endtask

    initial begin
        logic [31:0] pc;
        foreach (model[k]) model[k] = 1;
        m_bc = 0;
        m_mc = 0;

        step("rst0", 1, 0, 0, 0, 0, 0, 0);
        step("r034", 0, 1, 32'h100, 0, 0, 0, 0);
        check("r034_pred_c", {31'b0, predict_branch_taken_ID}, 0);
        check("r034_bcnt_c", 32'(branch_cnt), 0);
        check("r034_mcnt_c", 32'(mispredict_cnt), 0);

        step("r035_t1", 0, 1, 32'h100, 1, 32'h100, 1, 0);
        check("r035_wt_c", {31'b0, predict_branch_taken_ID}, 1);
        step("r035_t2", 0, 1, 32'h100, 1, 32'h100, 1, 0);
        step("r035_t3", 0, 1, 32'h100, 1, 32'h100, 1, 0);
        step("r035_nt", 0, 1, 32'h100, 1, 32'h100, 0, 1);
        check("r035_st_wt_c", {31'b0, predict_branch_taken_ID}, 1);

        step("r036_rst", 1, 0, 0, 0, 0, 0, 0);
        step("r036_nt1", 0, 1, 32'h40, 1, 32'h40, 0, 0);
        step("r036_nt2", 0, 1, 32'h40, 1, 32'h40, 0, 0);
        check("r036_snt_c", {31'b0, predict_branch_taken_ID}, 0);
        step("r036_l44", 0, 1, 32'h44, 0, 0, 0, 0);
        step("r036_t44", 0, 1, 32'h44, 1, 32'h44, 1, 0);
        check("r036_44wnt_c", {31'b0, predict_branch_taken_ID}, 1);
        step("r036_t40", 0, 1, 32'h40, 1, 32'h40, 1, 0);
        check("r036_40snt_c", {31'b0, predict_branch_taken_ID}, 0);

        step("r037_rst", 1, 0, 0, 0, 0, 0, 0);
        step("r037_same", 0, 1, 32'h200, 1, 32'h200, 1, 0);
        check("r037_next_c", {31'b0, predict_branch_taken_ID}, 1);

        step("r038_rst", 1, 0, 0, 0, 0, 0, 0);
        step("r038_upd", 0, 0, 0, 1, 32'h100, 1, 0);
        step("r038_alias", 0, 1, 32'h200, 0, 0, 0, 0);
        check("r038_alias_c", {31'b0, predict_branch_taken_ID}, 1);

        step("r039_rst", 1, 0, 0, 0, 0, 0, 0);
        step("r039_u1", 0, 0, 0, 1, 32'h300, 1, 0);
        step("r039_u2", 0, 0, 0, 1, 32'h304, 0, 1);
        step("r039_u3", 0, 0, 0, 1, 32'h300, 1, 0);
        step("r039_nofix", 0, 0, 0, 0, 32'h300, 1, 1);
        step("r039_u4", 0, 0, 0, 1, 32'h308, 0, 1);
        step("r039_u5", 0, 0, 0, 1, 32'h30c, 1, 0);
        check("r039_bcnt_c", 32'(branch_cnt), 5);
        check("r039_mcnt_c", 32'(mispredict_cnt), 2);
        step("r039_rstupd", 1, 0, 0, 1, 32'h100, 1, 1);
        check("r039_bcnt0_c", 32'(branch_cnt), 0);
        check("r039_mcnt0_c", 32'(mispredict_cnt), 0);
        for (int i = 0; i < 64; i++) begin
            pc = 32'(i) << 2;
            step("r039_wnt", 0, 1, pc, 1, pc, 1, 0);
            check("r039_wnt_c", {31'b0, predict_branch_taken_ID}, 1);
        end

        step("sat_rst", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            step("sat", 0, 0, 0, 1, 32'h80, 1, 1);
        check("sat_bcnt_c", 32'(branch_cnt), CMAX);
        check("sat_mcnt_c", 32'(mispredict_cnt), CMAX);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] lpc;
            logic [31:0] upc;
            lpc = (32'($urandom_range(0, 3)) << 8) |
                  (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            upc = (32'($urandom_range(0, 3)) << 8) |
                  (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            step("rand", ($urandom_range(0, 49) == 0), 1'($urandom),
                 lpc, 1'($urandom), upc, 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
